// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - shared state codes and symbol constants for the tx symbol scheduler
package tx_sched_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_PAYLOAD  = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam logic [1:0] PREAMBLE_EVEN = 2'b11;
    localparam logic [1:0] PREAMBLE_ODD  = 2'b00;

    // payload nibble layout: I in the upper pair, Q in the lower pair
    localparam int SYM_I_HI = 3;
    localparam int SYM_I_LO = 2;
    localparam int SYM_Q_HI = 1;
    localparam int SYM_Q_LO = 0;

    function automatic logic [1:0] preamble_sym(input logic odd);
        return odd ? PREAMBLE_ODD : PREAMBLE_EVEN;
    endfunction

endpackage

// File: rtl/tx_clk_ena_gen.sv
// rtl/tx_clk_ena_gen.sv - free-running sample and symbol clock-enable generator
module tx_clk_ena_gen #(
    parameter int SAM_DIV = 4,
    parameter int SPS     = 4
) (
    input  logic clk,
    input  logic reset,
    output logic sam_clk_ena,
    output logic sym_clk_ena
);

    localparam int SW = $clog2(SAM_DIV);
    localparam int YW = $clog2(SPS);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAM_DIV - 1);
    localparam logic [YW-1:0] SYM_LAST  = YW'(SPS - 1);

    logic [SW-1:0] samp_cnt;
    logic [YW-1:0] sym_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            samp_cnt    <= '0;
            sym_cnt     <= '0;
            sam_clk_ena <= 1'b0;
        end else begin
            samp_cnt    <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
            sam_clk_ena <= (samp_cnt == SAMP_LAST);
            if (sam_clk_ena)
                sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
        end
    end

    // symbol enable always lands on a sample enable
    assign sym_clk_ena = sam_clk_ena && (sym_cnt == SYM_LAST);

endmodule

// File: rtl/tx_sym_scheduler.sv
// rtl/tx_sym_scheduler.sv - frame sequencer (preamble, payload, flush) feeding the I/Q transmitter
module tx_sym_scheduler
    import tx_sched_pkg::*;
#(
    parameter int         SAM_DIV      = 4,
    parameter int         SPS          = 4,
    parameter int         PREAMBLE_LEN = 8,
    parameter int         FLUSH_LEN    = 6,
    parameter logic [1:0] PAD_SYM      = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] frame_len,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_del_i,
    input  logic [1:0]  cfg_del_q,
    input  logic        s_valid,
    input  logic [3:0]  s_data,
    output logic        s_ready,
    output logic        sam_clk_ena,
    output logic        sym_clk_ena,
    output logic [1:0]  syms_in_i,
    output logic [1:0]  syms_in_q,
    output logic [1:0]  del_i,
    output logic [1:0]  del_q,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam logic [15:0] PRE_LAST   = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_LEN - 1);

    logic [1:0]  state;
    logic [15:0] sym_idx;
    logic [15:0] len_q;
    logic        start_pend;
    logic        sam_ena;
    logic        sym_ena;

    tx_clk_ena_gen #(
        .SAM_DIV (SAM_DIV),
        .SPS     (SPS)
    ) u_clk_ena_gen (
        .clk         (clk),
        .reset       (reset),
        .sam_clk_ena (sam_ena),
        .sym_clk_ena (sym_ena)
    );

    assign sam_clk_ena = sam_ena;
    assign sym_clk_ena = sym_ena;
    assign s_ready     = (state == ST_PAYLOAD) && sym_ena;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sym_idx    <= '0;
            len_q      <= '0;
            start_pend <= 1'b0;
            syms_in_i  <= PAD_SYM;
            syms_in_q  <= PAD_SYM;
            del_i      <= '0;
            del_q      <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // config is frozen once a frame request is pending
                    if (cfg_wr && !start_pend) begin
                        del_i <= cfg_del_i;
                        del_q <= cfg_del_q;
                    end
                    if (sym_ena && start_pend) begin
                        state      <= ST_PREAMBLE;
                        sym_idx    <= '0;
                        start_pend <= 1'b0;
                    end else if (start && !start_pend) begin
                        start_pend <= 1'b1;
                        len_q      <= frame_len;
                        underrun   <= 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (sym_ena) begin
                        syms_in_i <= preamble_sym(sym_idx[0]);
                        syms_in_q <= preamble_sym(sym_idx[0]);
                        if (sym_idx == PRE_LAST) begin
                            sym_idx <= '0;
                            state   <= (len_q == 16'd0) ? ST_FLUSH : ST_PAYLOAD;
                        end else begin
                            sym_idx <= sym_idx + 16'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (s_ready) begin
                        if (s_valid) begin
                            syms_in_i <= s_data[SYM_I_HI:SYM_I_LO];
                            syms_in_q <= s_data[SYM_Q_HI:SYM_Q_LO];
                        end else begin
                            // missing symbol still consumes its slot
                            syms_in_i <= PAD_SYM;
                            syms_in_q <= PAD_SYM;
                            underrun  <= 1'b1;
                        end
                        if (sym_idx == len_q - 16'd1) begin
                            sym_idx <= '0;
                            state   <= ST_FLUSH;
                        end else begin
                            sym_idx <= sym_idx + 16'd1;
                        end
                    end
                end
                default: begin
                    if (sym_ena) begin
                        syms_in_i <= PAD_SYM;
                        syms_in_q <= PAD_SYM;
                        if (sym_idx == FLUSH_LAST) begin
                            sym_idx <= '0;
                            state   <= ST_IDLE;
                            done    <= 1'b1;
                        end else begin
                            sym_idx <= sym_idx + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sym_scheduler.sv
// tb/tb_tx_sym_scheduler.sv - self-checking bench for tx_sym_scheduler
module tb_tx_sym_scheduler;

    localparam int         SAM_DIV = 4;
    localparam int         SPS     = 4;
    localparam int         PRE     = 8;
    localparam int         FLUSH   = 6;
    localparam int         SYM_PER = SAM_DIV * SPS;
    localparam logic [1:0] PAD     = 2'b01;

    logic        clk = 1'b0;
    logic        reset, start, cfg_wr, s_valid;
    logic [15:0] frame_len;
    logic [1:0]  cfg_del_i, cfg_del_q;
    logic [3:0]  s_data;
    logic        s_ready, sam_clk_ena, sym_clk_ena, busy, done, underrun;
    logic [1:0]  syms_in_i, syms_in_q, del_i, del_q;

    always #5 clk = ~clk;

    tx_sym_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .frame_len   (frame_len),
        .cfg_wr      (cfg_wr),
        .cfg_del_i   (cfg_del_i),
        .cfg_del_q   (cfg_del_q),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .sam_clk_ena (sam_clk_ena),
        .sym_clk_ena (sym_clk_ena),
        .syms_in_i   (syms_in_i),
        .syms_in_q   (syms_in_q),
        .del_i       (del_i),
        .del_q       (del_q),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    typedef struct {
        int          len;
        logic [15:0] vmask;
        logic [11:0] d3;
        logic [1:0]  di;
        logic [1:0]  dq;
        bit          poke;
        int          exp_syms;
        bit          exp_und;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // reference model state: cycles since reset release and position within the frame
    int         cyc = 0;
    int         tcount = 0;
    bit         m_pend, m_busy, m_und, m_done;
    int         m_k, m_len;
    logic [1:0] m_di, m_dq, m_si, m_sq;

    bit         src_v[64];
    logic [3:0] src_d[64];
    int         src_idx = 0;
    logic [3:0] sym_log[$];
    int         done_cnt = 0, done_cyc = 0, rise_cyc = 0;
    int         first_sam = -1, first_sym = -1;
    logic       prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        bit         se, se_now, busy_before, exp_rdy;
        logic [13:0] exp_v, act_v;
        s_valid     = src_v[src_idx];
        s_data      = src_d[src_idx];
        se          = (cyc > 0) && (cyc % SYM_PER == 0);
        busy_before = m_busy;
        @(posedge clk);
        m_done = 1'b0;
        if (!reset) begin
            cyc = 0; m_pend = 0; m_busy = 0; m_und = 0; m_k = 0;
            m_di = 2'b00; m_dq = 2'b00; m_si = PAD; m_sq = PAD;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (cfg_wr && !m_pend) begin m_di = cfg_del_i; m_dq = cfg_del_q; end
                if (se && m_pend) begin
                    m_busy = 1; m_k = 0; m_pend = 0;
                end else if (start && !m_pend) begin
                    m_pend = 1; m_len = int'(frame_len); m_und = 0;
                end
            end else if (se) begin
                if (m_k < PRE) begin
                    m_si = (m_k % 2 == 0) ? 2'b11 : 2'b00;
                    m_sq = m_si;
                end else if (m_k < PRE + m_len) begin
                    if (s_valid) begin
                        m_si = s_data[3:2]; m_sq = s_data[1:0];
                    end else begin
                        m_si = PAD; m_sq = PAD; m_und = 1;
                    end
                    src_idx++;
                end else begin
                    m_si = PAD; m_sq = PAD;
                end
                m_k++;
                if (m_k == PRE + m_len + FLUSH) begin m_busy = 0; m_done = 1; end
            end
        end
        tcount++;
        #1;
        se_now  = (cyc > 0) && (cyc % SYM_PER == 0);
        exp_rdy = m_busy && se_now && (m_k >= PRE) && (m_k < PRE + m_len);
        exp_v = {(cyc > 0) && (cyc % SAM_DIV == 0), se_now, exp_rdy, m_si, m_sq,
                 m_di, m_dq, m_busy, m_done, m_und};
        act_v = {sam_clk_ena, sym_clk_ena, s_ready, syms_in_i, syms_in_q,
                 del_i, del_q, busy, done, underrun};
        check($sformatf("cyc%0d outputs", cyc), 32'(act_v), 32'(exp_v));
        if (se && busy_before) sym_log.push_back({syms_in_i, syms_in_q});
        if (done === 1'b1) begin done_cnt++; done_cyc = tcount; end
        if (busy === 1'b1 && prev_busy !== 1'b1) rise_cyc = tcount;
        prev_busy = busy;
        if (sam_clk_ena === 1'b1 && first_sam < 0) first_sam = cyc;
        if (sym_clk_ena === 1'b1 && first_sym < 0) first_sym = cyc;
    endtask

    task automatic run_frame(input int len, input logic [1:0] di, input logic [1:0] dq, input bit poke);
        int budget, d0;
        src_idx = 0;
        sym_log.delete();
        d0 = done_cnt;
        repeat ($urandom_range(0, 20)) step();
        start = 1; cfg_wr = 1; frame_len = len[15:0]; cfg_del_i = di; cfg_del_q = dq;
        step();
        start = 0; cfg_wr = 0;
        check("underrun cleared on start", 32'(underrun), 32'(0));
        budget = 0;
        while (done_cnt == d0 && budget < 3000) begin
            if (poke && busy) begin
                start = 1'($urandom_range(0, 1)); cfg_wr = 1'($urandom_range(0, 1));
                cfg_del_i = ~di; cfg_del_q = ~dq; frame_len = 16'd7;
            end
            step();
            budget++;
        end
        start = 0; cfg_wr = 0;
        if (budget >= 3000) begin
            checks++; errors++;
            $display("FAIL frame timeout: no done within %0d cycles", budget);
        end
    endtask

    vec_t       tbl[4];
    logic [3:0] exp0[17];
    logic [11:0] d3;

    initial begin
        reset = 0; start = 0; cfg_wr = 0; frame_len = 0; cfg_del_i = 0; cfg_del_q = 0;
        s_valid = 0; s_data = 0;
        for (int j = 0; j < 64; j++) begin src_v[j] = 0; src_d[j] = 0; end

        tbl[0] = '{3, 16'h0007, 12'hE16, 2'd2, 2'd1, 1'b0, 17, 1'b0};
        tbl[1] = '{4, 16'h000D, 12'h000, 2'd0, 2'd3, 1'b0, 18, 1'b1};
        tbl[2] = '{0, 16'h0000, 12'h000, 2'd1, 2'd2, 1'b0, 14, 1'b0};
        tbl[3] = '{2, 16'h0003, 12'h000, 2'd3, 2'd0, 1'b1, 16, 1'b0};
        exp0 = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0,
                 4'hE, 4'h1, 4'h6, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};

        // idle after reset: enable cadence only
        repeat (3) step();
        reset = 1;
        repeat (64) step();
        check("first sam_clk_ena", 32'(first_sam), 32'(4));
        check("first sym_clk_ena", 32'(first_sym), 32'(16));
        check("idle syms", 32'({syms_in_i, syms_in_q, busy}), 32'({PAD, PAD, 1'b0}));

        for (int i = 0; i < 4; i++) begin
            d3 = tbl[i].d3;
            for (int j = 0; j < 64; j++) begin
                src_v[j] = (j < 16) ? tbl[i].vmask[j] : 1'b1;
                src_d[j] = (j < 3) ? d3[11 - 4*j -: 4] : 4'($urandom);
            end
            run_frame(tbl[i].len, tbl[i].di, tbl[i].dq, tbl[i].poke);
            check($sformatf("vec%0d latency", i), 32'(done_cyc - rise_cyc), 32'(tbl[i].exp_syms * SYM_PER));
            check($sformatf("vec%0d symbol count", i), 32'(sym_log.size()), 32'(tbl[i].exp_syms));
            check($sformatf("vec%0d underrun", i), 32'(underrun), 32'(tbl[i].exp_und));
            check($sformatf("vec%0d delay", i), 32'({del_i, del_q}), 32'({tbl[i].di, tbl[i].dq}));
            if (i == 0) begin
                for (int j = 0; j < 17; j++)
                    if (j < sym_log.size())
                        check($sformatf("vec0 sym%0d", j), 32'(sym_log[j]), 32'(exp0[j]));
            end
            if (i == 1 && sym_log.size() > 9)
                check("vec1 underrun slot pad", 32'(sym_log[9]), 32'(4'h5));
        end

        // reset in the middle of the payload aborts without done
        begin
            int b, d0;
            src_idx = 0;
            for (int j = 0; j < 64; j++) begin src_v[j] = 1; src_d[j] = 4'($urandom); end
            d0 = done_cnt;
            start = 1; frame_len = 16'd6;
            step();
            start = 0;
            b = 0;
            while (!(m_busy && m_k >= PRE + 1) && b < 2000) begin step(); b++; end
            if (b >= 2000) begin
                checks++; errors++;
                $display("FAIL payload reach timeout: %0d cycles", b);
            end
            reset = 0;
            step();
            reset = 1;
            check("abort reset values",
                  32'({sam_clk_ena, sym_clk_ena, s_ready, syms_in_i, syms_in_q, del_i, del_q, busy, done, underrun}),
                  32'({3'b000, PAD, PAD, 4'b0000, 3'b000}));
            repeat (40) step();
            check("no done after abort", 32'(done_cnt - d0), 32'(0));
            run_frame(2, 2'd1, 2'd1, 1'b0);
            check("frame after abort done", 32'(done_cnt - d0), 32'(1));
        end

        // randomized frames against the model
        for (int r = 0; r < 6; r++) begin
            int len, d0;
            len = $urandom_range(0, 12);
            for (int j = 0; j < 64; j++) begin
                src_v[j] = ($urandom_range(0, 4) != 0);
                src_d[j] = 4'($urandom);
            end
            d0 = done_cnt;
            run_frame(len, 2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
            check($sformatf("rand%0d latency", r), 32'(done_cyc - rise_cyc), 32'((PRE + len + FLUSH) * SYM_PER));
            check($sformatf("rand%0d single done", r), 32'(done_cnt - d0), 32'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
